mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/arb_priority_sel.sv | 33 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared defaults and arbiter state encoding for the memory-port arbiter.
package riscv_pkg;

   localparam int unsigned DEFAULT_AW           = 32;
   localparam int unsigned DEFAULT_DW           = 32;
   localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_GRANT_IF  = 2'd1;
   localparam logic [1:0] ST_GRANT_MEM = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      GRANT_IF  = ST_GRANT_IF,
      GRANT_MEM = ST_GRANT_MEM
   } arb_state_t;

   // Width of a counter that must hold 0..limit; never narrower than one bit.
   function automatic int unsigned starve_cw(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Priority decision: MEM normally wins; IF wins once it has been starved for
// STARVE_LIMIT consecutive MEM grants, or when MEM is not requesting.
module arb_priority_sel
   import riscv_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int unsigned CW           = starve_cw(STARVE_LIMIT)
) (
   input  logic          if_req,
   input  logic          mem_req,
   input  logic [CW-1:0] starve_cnt,
   output logic          grant_if,
   output logic          grant_mem
);

   logic if_starved;

   assign if_starved = if_req && (starve_cnt == CW'(STARVE_LIMIT));

   // One-hot (or empty) grant selection.
   always_comb begin
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      if (if_starved) begin
         grant_if = 1'b1;
      end else if (mem_req) begin
         grant_mem = 1'b1;
      end else if (if_req) begin
         grant_if = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single shared RAM port between the fetch stage and the MEM stage.
// The winner's request fields are latched on the grant edge and held until the
// RAM completes; completion produces a one-cycle ack in the following cycle.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int unsigned AW           = DEFAULT_AW,
   parameter int unsigned DW           = DEFAULT_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          mem_req,
   input  logic          mem_we,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic          mem_ack,
   output logic [DW-1:0] mem_rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   input  logic          ram_ready,
   output logic          stall_if,
   output logic          stall_mem
);

   localparam int unsigned CW = starve_cw(STARVE_LIMIT);

   arb_state_t    state_q, state_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          grant_if, grant_mem;
   logic          take_if, take_mem;
   logic          done_if, done_mem;
   logic          ram_we_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_wdata_q;
   logic          if_ack_q, mem_ack_q;
   logic [DW-1:0] if_rdata_q, mem_rdata_q;

   arb_priority_sel #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CW           (CW)
   ) u_sel (
      .if_req     (if_req),
      .mem_req    (mem_req),
      .starve_cnt (starve_q),
      .grant_if   (grant_if),
      .grant_mem  (grant_mem)
   );

   // Grants only take effect in IDLE; completions only count inside a grant.
   assign take_if  = (state_q == IDLE) && grant_if;
   assign take_mem = (state_q == IDLE) && grant_mem;
   assign done_if  = (state_q == GRANT_IF) && ram_ready;
   assign done_mem = (state_q == GRANT_MEM) && ram_ready;

   // Next-state and starvation counter update.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      unique case (state_q)
         IDLE: begin
            if (take_if) begin
               state_d = GRANT_IF;
            end else if (take_mem) begin
               state_d = GRANT_MEM;
            end
         end
         GRANT_IF, GRANT_MEM: begin
            if (ram_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!if_req || take_if) begin
         starve_d = '0;
      end else if (take_mem && (starve_q != CW'(STARVE_LIMIT))) begin
         starve_d = starve_q + CW'(1);
      end
   end

   // State, latched request fields, acks and read-data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         if_ack_q  <= done_if;
         mem_ack_q <= done_mem;
         if (take_if) begin
            ram_we_q    <= 1'b0;
            ram_addr_q  <= if_addr;
            ram_wdata_q <= '0;
         end else if (take_mem) begin
            ram_we_q    <= mem_we;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
         end
         if (done_if) begin
            if_rdata_q <= ram_rdata;
         end
         // Stores leave the load-data register untouched.
         if (done_mem && !ram_we_q) begin
            mem_rdata_q <= ram_rdata;
         end
      end
   end

   assign ram_en    = (state_q != IDLE);
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign if_ack    = if_ack_q;
   assign mem_ack   = mem_ack_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign stall_if  = if_req & ~if_ack_q;
   assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, mem_req, mem_we, ram_ready;
   logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
   logic        if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem;
   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the port, the latched transaction, results.
   int          m_owner = 0;  // 0 none, 1 fetch, 2 mem
   bit          m_we = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_mem_rdata = '0;
   bit          m_if_ack = 0, m_mem_ack = 0;
   int          m_starve = 0;

   mem_port_arbiter #(
      .STARVE_LIMIT (LIMIT),
      .AW           (32),
      .DW           (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ready (ram_ready),
      .stall_if  (stall_if),
      .stall_mem (stall_mem)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      int win = 0;
      bit nia = 0, nma = 0;
      if (reset) begin
         m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0;
         m_if_rdata = '0; m_mem_rdata = '0; m_if_ack = 0; m_mem_ack = 0; m_starve = 0;
         return;
      end
      if (m_owner == 0) begin
         if (if_req && m_starve >= LIMIT) win = 1;
         else if (mem_req) win = 2;
         else if (if_req) win = 1;
         if (win == 1) begin
            m_we = 0; m_addr = if_addr; m_wdata = '0;
         end else if (win == 2) begin
            m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
         end
         m_owner = win;
      end else if (ram_ready) begin
         if (m_owner == 1) begin
            nia = 1; m_if_rdata = ram_rdata;
         end else begin
            nma = 1;
            if (!m_we) m_mem_rdata = ram_rdata;
         end
         m_owner = 0;
      end
      m_if_ack  = nia;
      m_mem_ack = nma;
      if (!if_req || win == 1) m_starve = 0;
      else if (win == 2) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Sample mid-cycle and compare every output against the model.
   task automatic sample(input string tag);
      @(negedge clk);
      check_eq({tag, ".ram_en"},    ram_en,    32'(m_owner != 0));
      check_eq({tag, ".ram_we"},    ram_we,    32'(m_we));
      check_eq({tag, ".ram_addr"},  ram_addr,  m_addr);
      check_eq({tag, ".ram_wdata"}, ram_wdata, m_wdata);
      check_eq({tag, ".if_ack"},    if_ack,    32'(m_if_ack));
      check_eq({tag, ".mem_ack"},   mem_ack,   32'(m_mem_ack));
      check_eq({tag, ".if_rdata"},  if_rdata,  m_if_rdata);
      check_eq({tag, ".mem_rdata"}, mem_rdata, m_mem_rdata);
      check_eq({tag, ".stall_if"},  stall_if,  32'(if_req && !m_if_ack));
      check_eq({tag, ".stall_mem"}, stall_mem, 32'(mem_req && !m_mem_ack));
      check_eq({tag, ".ack_excl"},  32'(if_ack & mem_ack), 32'd0);
   endtask

   initial begin
      int seq[$];
      int exp_seq[10];
      bit prev_en;

      reset = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; ram_ready = 0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
      repeat (2) advance();
      sample("reset");
      check_eq("reset.ram_en_const", ram_en, 0);
      check_eq("reset.ram_addr_const", ram_addr, 0);
      reset = 1'b0;
      advance();

      // Lone fetch with minimum latency.
      if_req = 1; if_addr = 32'h10;
      sample("ifrd.c0");
      check_eq("ifrd.c0.stall", stall_if, 1);
      advance();
      ram_ready = 1; ram_rdata = 32'hDEADBEEF;
      sample("ifrd.c1");
      check_eq("ifrd.c1.addr", ram_addr, 32'h10);
      check_eq("ifrd.c1.stall", stall_if, 1);
      advance();
      ram_ready = 0; ram_rdata = 32'h0BADF00D;
      sample("ifrd.c2");
      check_eq("ifrd.c2.ack", if_ack, 1);
      check_eq("ifrd.c2.rdata", if_rdata, 32'hDEADBEEF);
      if_req = 0;
      advance();
      sample("ifrd.c3");
      check_eq("ifrd.c3.ack_pulse", if_ack, 0);

      // Simultaneous requests: store wins first, fetch follows.
      advance();
      if_req = 1; if_addr = 32'h20;
      mem_req = 1; mem_we = 1; mem_addr = 32'h0C; mem_wdata = 32'h5;
      sample("both.c0");
      advance();
      ram_ready = 1; ram_rdata = 32'h12345678;
      sample("both.c1");
      check_eq("both.c1.we", ram_we, 1);
      check_eq("both.c1.addr", ram_addr, 32'h0C);
      advance();
      ram_ready = 0;
      sample("both.c2");
      check_eq("both.c2.mem_ack", mem_ack, 1);
      check_eq("both.c2.mem_rdata", mem_rdata, 32'h0);
      mem_req = 0;
      advance();
      sample("both.c3");
      check_eq("both.c3.if_grant_addr", ram_addr, 32'h20);
      check_eq("both.c3.if_grant_we", ram_we, 0);
      ram_ready = 1;
      advance();
      ram_ready = 0;
      sample("both.c4");
      if_req = 0;
      advance();
      sample("both.c5");
      advance();

      // Starvation: MEM held with IF waiting.
      if_addr = 32'h100; mem_addr = 32'h200; mem_we = 0;
      if_req = 1; mem_req = 1; ram_ready = 1;
      prev_en = 0;
      for (int c = 0; c < 24 && seq.size() < 10; c++) begin
         sample("starve");
         if (ram_en && !prev_en) seq.push_back((ram_addr == 32'h100) ? 1 : 2);
         prev_en = ram_en;
         advance();
      end
      exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
      check_eq("starve.ngrants", seq.size(), 10);
      for (int i = 0; i < seq.size() && i < 10; i++) check_eq("starve.order", seq[i], exp_seq[i]);
      if_req = 0; mem_req = 0;
      repeat (3) begin sample("starve.drain"); advance(); end
      ram_ready = 0;
      sample("starve.idle");
      advance();

      // Slow RAM while the MEM address moves mid-grant.
      mem_req = 1; mem_we = 0; mem_addr = 32'h40;
      sample("slow.c0");
      advance();
      for (int k = 0; k < 3; k++) begin
         mem_addr = $urandom;
         sample("slow.wait");
         check_eq("slow.hold_addr", ram_addr, 32'h40);
         advance();
      end
      ram_ready = 1; ram_rdata = 32'hCAFE0001; mem_addr = $urandom;
      sample("slow.ready");
      check_eq("slow.ready.no_ack", mem_ack, 0);
      advance();
      ram_ready = 0;
      sample("slow.ack");
      check_eq("slow.ack", mem_ack, 1);
      check_eq("slow.rdata", mem_rdata, 32'hCAFE0001);
      mem_req = 0;
      advance();

      // Reset in the middle of a MEM grant, with ram_ready in the same cycle.
      mem_req = 1; mem_we = 1; mem_addr = 32'h80; mem_wdata = 32'h77;
      sample("rstg.c0");
      advance();
      sample("rstg.c1");
      check_eq("rstg.c1.en", ram_en, 1);
      reset = 1; ram_ready = 1;
      advance();
      reset = 0; ram_ready = 0; mem_req = 0;
      sample("rstg.c2");
      check_eq("rstg.c2.en", ram_en, 0);
      check_eq("rstg.c2.mem_ack", mem_ack, 0);
      check_eq("rstg.c2.wdata", ram_wdata, 0);
      advance();
      sample("rstg.c3");
      check_eq("rstg.c3.mem_ack", mem_ack, 0);

      // Spurious ram_ready with no requests.
      ram_ready = 1;
      for (int k = 0; k < 3; k++) begin
         sample("spur");
         check_eq("spur.en", ram_en, 0);
         check_eq("spur.acks", 32'(if_ack | mem_ack), 0);
         advance();
      end
      ram_ready = 0;

      // Randomized traffic with back-to-back requests and occasional reset.
      for (int c = 0; c < 3000; c++) begin
         sample("rand");
         if (if_req) begin
            if (if_ack && $urandom_range(3) != 0) if_req = 0;
         end else if ($urandom_range(2) == 0) begin
            if_req = 1;
         end
         if (mem_req) begin
            if (mem_ack && $urandom_range(3) != 0) mem_req = 0;
         end else if ($urandom_range(2) == 0) begin
            mem_req = 1;
         end
         if_addr   = $urandom;
         mem_addr  = $urandom;
         mem_wdata = $urandom;
         mem_we    = 1'($urandom_range(1));
         ram_ready = ($urandom_range(2) == 0);
         ram_rdata = $urandom;
         reset     = ($urandom_range(150) == 0);
         advance();
      end
      reset = 0;
      sample("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
